// File: rtl/flags_ctrl_if.sv
// Bus bundle between flags_ctrl and its requesters / stack unit / flags consumers.
// Handshake rules: a requester holds req and its data until it sees gnt; gnt is
// combinational in the request cycle. push_valid holds with stable push_data until push_ready.
interface flags_ctrl_if #(
    parameter int ALU_W = 16
);
    logic             alu_req;
    logic             alu_gnt;
    logic             alu_byte;
    logic [ALU_W-1:0] alu_result;
    logic             carry_in;
    logic             aux_in;
    logic             overflow_in;
    logic             op_req;
    logic [2:0]       op_code;
    logic             op_gnt;
    logic             ld_req;
    logic [15:0]      ld_data;
    logic [15:0]      ld_mask;
    logic             ld_gnt;
    logic             int_req;
    logic             push_valid;
    logic [15:0]      push_data;
    logic             push_ready;
    logic             int_done;
    logic             instr_ret;
    logic             trap_req;
    logic [15:0]      flags;
    logic [1:0]       state_dbg;

    modport master (
        output alu_req, alu_byte, alu_result, carry_in, aux_in, overflow_in,
        output op_req, op_code, ld_req, ld_data, ld_mask, int_req,
        output push_ready, instr_ret,
        input  alu_gnt, op_gnt, ld_gnt, push_valid, push_data, int_done,
        input  trap_req, flags, state_dbg
    );

    modport slave (
        input  alu_req, alu_byte, alu_result, carry_in, aux_in, overflow_in,
        input  op_req, op_code, ld_req, ld_data, ld_mask, int_req,
        input  push_ready, instr_ret,
        output alu_gnt, op_gnt, ld_gnt, push_valid, push_data, int_done,
        output trap_req, flags, state_dbg
    );
endinterface

// File: rtl/flags_ctrl.sv
// 8086 FLAGS register owner: arbitrates interrupt entry, load, direct ops and ALU updates.
// Optional single-step trap support is enabled by defining FLAGS_CTRL_TRAP_EN.
module flags_ctrl #(
    parameter int          ALU_W     = 16,
    parameter logic [15:0] RST_FLAGS = 16'hF002
) (
    input logic         clk,
    input logic         rst_n,
    flags_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INT_SAVE = 2'd1,
        INT_CLR  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] flags_q, flags_d;
    logic [15:0] push_data_q, push_data_d;
    logic        alu_gnt, op_gnt, ld_gnt, push_valid, int_done;
    logic [15:0] alu_flags, op_flags, ld_flags;

    // Reserved bits are fixed; without the trap option TF can never be set.
    function automatic logic [15:0] legalize(input logic [15:0] v);
        logic [15:0] r;
        r = (v | 16'hF002) & ~16'h0028;
`ifndef FLAGS_CTRL_TRAP_EN
        r[8] = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [15:0] apply_op(input logic [15:0] f, input logic [2:0] code);
        logic [15:0] r;
        r = f;
        case (code)
            3'd0:    r[0]  = 1'b0;
            3'd1:    r[0]  = 1'b1;
            3'd2:    r[0]  = ~f[0];
            3'd3:    r[9]  = 1'b0;
            3'd4:    r[9]  = 1'b1;
            3'd5:    r[10] = 1'b0;
            3'd6:    r[10] = 1'b1;
            default: r     = f;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_flags     = flags_q;
        alu_flags[0]  = bus.carry_in;
        alu_flags[2]  = ~^bus.alu_result[7:0];
        alu_flags[4]  = bus.aux_in;
        alu_flags[6]  = bus.alu_byte ? (bus.alu_result[7:0] == 8'h00) : (bus.alu_result == '0);
        alu_flags[7]  = bus.alu_byte ? bus.alu_result[7] : bus.alu_result[ALU_W-1];
        alu_flags[11] = bus.overflow_in;
        alu_flags     = legalize(alu_flags);
        op_flags      = legalize(apply_op(flags_q, bus.op_code));
        ld_flags      = legalize((flags_q & ~bus.ld_mask) | (bus.ld_data & bus.ld_mask));
    end

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        push_data_d = push_data_q;
        alu_gnt     = 1'b0;
        op_gnt      = 1'b0;
        ld_gnt      = 1'b0;
        push_valid  = 1'b0;
        int_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.int_req) begin
                    state_d     = INT_SAVE;
                    push_data_d = flags_q;
                end else if (bus.ld_req) begin
                    ld_gnt  = 1'b1;
                    flags_d = ld_flags;
                end else if (bus.op_req) begin
                    op_gnt  = 1'b1;
                    flags_d = op_flags;
                end else if (bus.alu_req) begin
                    alu_gnt = 1'b1;
                    flags_d = alu_flags;
                end
            end
            INT_SAVE: begin
                push_valid = 1'b1;
                // Clear lands on the handshake edge so INT_CLR already shows IF=TF=0.
                if (bus.push_ready) begin
                    flags_d[9] = 1'b0;
                    flags_d[8] = 1'b0;
                    state_d    = INT_CLR;
                end
            end
            INT_CLR: begin
                int_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flags_q     <= RST_FLAGS;
            push_data_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            push_data_q <= push_data_d;
        end
    end

`ifdef FLAGS_CTRL_TRAP_EN
    logic trap_req_q, trap_req_d;

    // Uses the pre-write TF, so a write that sets TF cannot trap in the same cycle.
    assign trap_req_d = bus.instr_ret & flags_q[8] & (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_req_q <= 1'b0;
        else        trap_req_q <= trap_req_d;
    end

    assign bus.trap_req = trap_req_q;
`else
    logic unused_instr_ret;
    assign unused_instr_ret = bus.instr_ret;
    assign bus.trap_req     = 1'b0;
`endif

    assign bus.alu_gnt    = alu_gnt;
    assign bus.op_gnt     = op_gnt;
    assign bus.ld_gnt     = ld_gnt;
    assign bus.push_valid = push_valid;
    assign bus.push_data  = push_data_q;
    assign bus.int_done   = int_done;
    assign bus.flags      = flags_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_flags_ctrl.sv
// Self-checking bench for flags_ctrl: directed scenarios then randomized traffic,
// all checked each cycle against a behavioural FLAGS model with a push scoreboard.
module tb_flags_ctrl;

    logic clk;
    logic rst_n;

    flags_ctrl_if #(.ALU_W(16)) bus ();

    flags_ctrl #(.ALU_W(16), .RST_FLAGS(16'hF002)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FLAGS_CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FLAGS value, interrupt phase (0 idle, 1 pushing, 2 done), trap.
    logic [15:0] m_flags;
    int          m_phase;
    logic        exp_trap;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] legal(input logic [15:0] v);
        logic [15:0] r;
        r        = v;
        r[15:12] = 4'hF;
        r[1]     = 1'b1;
        r[3]     = 1'b0;
        r[5]     = 1'b0;
        if (!TRAP_EN) r[8] = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] alu_model(input logic [15:0] f, input logic [15:0] res,
                                              input logic byt, input logic c,
                                              input logic a, input logic o);
        logic [15:0] r;
        r     = f;
        r[0]  = c;
        r[2]  = ($countones(res[7:0]) % 2) == 0;
        r[4]  = a;
        r[6]  = byt ? (res[7:0] == 8'd0) : (res == 16'd0);
        r[7]  = byt ? res[7] : res[15];
        r[11] = o;
        return legal(r);
    endfunction

    function automatic logic [15:0] op_model(input logic [15:0] f, input logic [2:0] code);
        logic [15:0] r;
        r = f;
        case (code)
            3'd0: r[0]  = 1'b0;
            3'd1: r[0]  = 1'b1;
            3'd2: r[0]  = !f[0];
            3'd3: r[9]  = 1'b0;
            3'd4: r[9]  = 1'b1;
            3'd5: r[10] = 1'b0;
            3'd6: r[10] = 1'b1;
            default: ;
        endcase
        return legal(r);
    endfunction

    task automatic clear_inputs();
        bus.alu_req = 0; bus.alu_byte = 0; bus.alu_result = 0;
        bus.carry_in = 0; bus.aux_in = 0; bus.overflow_in = 0;
        bus.op_req = 0; bus.op_code = 0;
        bus.ld_req = 0; bus.ld_data = 0; bus.ld_mask = 0;
        bus.int_req = 0; bus.push_ready = 0; bus.instr_ret = 0;
    endtask

    task automatic model_reset();
        m_flags  = 16'hF002;
        m_phase  = 0;
        exp_trap = 1'b0;
        exp_q.delete();
    endtask

    // One clock: compare everything at negedge, advance model, retire granted requests.
    task automatic step();
        logic        e_ld, e_op, e_alu, ntrap;
        logic [15:0] nf;
        int          nphase;
        @(negedge clk);
        e_ld = 0; e_op = 0; e_alu = 0;
        nf = m_flags; nphase = m_phase;
        if (m_phase == 0 && !bus.int_req) begin
            if (bus.ld_req)       e_ld  = 1;
            else if (bus.op_req)  e_op  = 1;
            else if (bus.alu_req) e_alu = 1;
        end
        check("ld_gnt",     {15'd0, bus.ld_gnt},     {15'd0, e_ld});
        check("op_gnt",     {15'd0, bus.op_gnt},     {15'd0, e_op});
        check("alu_gnt",    {15'd0, bus.alu_gnt},    {15'd0, e_alu});
        check("flags",      bus.flags,               m_flags);
        check("push_valid", {15'd0, bus.push_valid}, {15'd0, m_phase == 1});
        check("int_done",   {15'd0, bus.int_done},   {15'd0, m_phase == 2});
        check("trap_req",   {15'd0, bus.trap_req},   {15'd0, exp_trap});
        if (m_phase == 1 && exp_q.size() > 0) check("push_data", bus.push_data, exp_q[0]);
        ntrap = TRAP_EN && bus.instr_ret && m_flags[8] && (m_phase == 0);
        case (m_phase)
            0: begin
                if (bus.int_req) begin
                    exp_q.push_back(m_flags);
                    nphase = 1;
                end else if (e_ld) nf = legal((m_flags & ~bus.ld_mask) | (bus.ld_data & bus.ld_mask));
                else if (e_op)  nf = op_model(m_flags, bus.op_code);
                else if (e_alu) nf = alu_model(m_flags, bus.alu_result, bus.alu_byte,
                                               bus.carry_in, bus.aux_in, bus.overflow_in);
            end
            1: if (bus.push_ready) begin
                nf[9] = 1'b0;
                nf[8] = 1'b0;
                void'(exp_q.pop_front());
                nphase = 2;
            end
            default: nphase = 0;
        endcase
        @(posedge clk);
        #1;
        if (m_phase == 2) bus.int_req = 0;
        m_flags  = nf;
        m_phase  = nphase;
        exp_trap = ntrap;
        if (e_ld)  bus.ld_req  = 0;
        if (e_op)  bus.op_req  = 0;
        if (e_alu) bus.alu_req = 0;
        bus.instr_ret = 0;
    endtask

    task automatic rand_drive();
        if (!bus.ld_req && $urandom_range(0, 3) == 0) begin
            bus.ld_req  = 1;
            bus.ld_data = 16'($urandom);
            bus.ld_mask = ($urandom_range(0, 1) == 1) ? 16'h00D5 : 16'($urandom);
        end
        if (!bus.op_req && $urandom_range(0, 2) == 0) begin
            bus.op_req  = 1;
            bus.op_code = 3'($urandom_range(0, 7));
        end
        if (!bus.alu_req && $urandom_range(0, 1) == 0) begin
            bus.alu_req     = 1;
            bus.alu_byte    = 1'($urandom_range(0, 1));
            bus.alu_result  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            bus.carry_in    = 1'($urandom_range(0, 1));
            bus.aux_in      = 1'($urandom_range(0, 1));
            bus.overflow_in = 1'($urandom_range(0, 1));
        end
        bus.push_ready = 1'($urandom_range(0, 1));
        bus.instr_ret  = ($urandom_range(0, 2) == 0);
        if (m_phase == 0 && !bus.int_req && $urandom_range(0, 15) == 0) bus.int_req = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check("rst_flags", bus.flags, 16'hF002);
        step();

        // Byte ALU op with zero low byte
        bus.alu_req = 1; bus.alu_byte = 1; bus.alu_result = 16'h0100; bus.carry_in = 1;
        step();
        check("alu_byte_flags", bus.flags, 16'hF047);

        // STC beats a concurrent ALU request; ALU then lands with its held data
        bus.op_req = 1; bus.op_code = 3'd1;
        bus.alu_req = 1; bus.alu_byte = 0; bus.alu_result = 16'h8000;
        bus.carry_in = 0; bus.aux_in = 1; bus.overflow_in = 0;
        step();
        check("stc_cf", {15'd0, bus.flags[0]}, 16'd1);
        step();
        check("alu_word_flags", bus.flags, 16'hF096);

        // SAHF-style masked load
        bus.ld_req = 1; bus.ld_data = 16'hFFFF; bus.ld_mask = 16'h00D5;
        step();
        check("sahf_flags", bus.flags, 16'hF0D7);

        // STI, then load TF with a coincident instr_ret, then a plain instr_ret
        bus.op_req = 1; bus.op_code = 3'd4;
        step();
        bus.ld_req = 1; bus.ld_data = 16'h0100; bus.ld_mask = 16'h0100; bus.instr_ret = 1;
        step();
        check("tf_load", {15'd0, bus.flags[8]}, {15'd0, TRAP_EN});
        step();
        check("no_same_cycle_trap", {15'd0, bus.trap_req}, 16'd0);
        bus.instr_ret = 1;
        step();
        check("trap_pulse", {15'd0, bus.trap_req}, {15'd0, TRAP_EN});
        step();

        // Interrupt entry with stalled stack unit and a stalled ALU request
        bus.int_req = 1; bus.push_ready = 0;
        bus.alu_req = 1; bus.alu_byte = 0; bus.alu_result = 16'h0001;
        bus.carry_in = 0; bus.aux_in = 0; bus.overflow_in = 0;
        step();
        check("int_push_data", bus.push_data, TRAP_EN ? 16'hF3D7 : 16'hF2D7);
        repeat (3) step();
        bus.push_ready = 1;
        step();
        check("int_if_clear", {14'd0, bus.flags[9:8]}, 16'd0);
        bus.push_ready = 0;
        repeat (3) step();

        for (int i = 0; i < 400; i++) begin
            rand_drive();
            step();
        end

        // Reset asserted in the middle of an interrupt save
        for (int i = 0; i < 8 && m_phase != 0; i++) begin
            bus.push_ready = 1;
            step();
        end
        clear_inputs();
        bus.int_req = 1;
        repeat (2) step();
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_push_valid", {15'd0, bus.push_valid}, 16'd0);
        check("mid_rst_flags",      bus.flags,               16'hF002);
        check("mid_rst_int_done",   {15'd0, bus.int_done},   16'd0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
